// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path: width helper and FSM state encoding.
package uart_transmitter_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Smallest number of bits able to index 'value' distinct states.
  function automatic int CeilLog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Parallel-side handshake of the UART transmitter: word plus send strobe in, line and status out.
interface uart_transmitter_if #(
  parameter int WORD_LENGHT = 8
);
  logic [WORD_LENGHT-1:0] TX_in;
  logic                   send;
  logic                   TX_out;
  logic                   busy;
  logic                   done;

  modport master (output TX_in, send, input TX_out, busy, done);
  modport slave  (input TX_in, send, output TX_out, busy, done);
endinterface

// File: rtl/uart_transmitter_baud_tick_gen.sv
// Bit-period timebase: one-cycle tick every FREQUENCY/BAUDRATE clocks, restartable on demand.
module uart_transmitter_baud_tick_gen
  import uart_transmitter_pkg::*;
#(
  parameter int FREQUENCY = 50000000,
  parameter int BAUDRATE  = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int DIV    = FREQUENCY / BAUDRATE;
  localparam int TICK_W = CeilLog2(DIV);

  logic [TICK_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (restart || cnt_reg == TICK_W'(DIV - 1)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + TICK_W'(1);
    end
  end

  // Not masked by restart: the final stop-bit tick and a new acceptance can coincide.
  assign tick = (cnt_reg == TICK_W'(DIV - 1));

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits; registered outputs.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 50000000,
  parameter int BAUDRATE    = 9600,
  parameter bit PARITY_EN   = 1'b0,
  parameter bit PARITY_ODD  = 1'b0,
  parameter int STOP_BITS   = 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   bus
);
  localparam int BIT_W = CeilLog2(WORD_LENGHT + 1);

  tx_state_t              state_reg, state_next;
  logic [WORD_LENGHT-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic                   parity_reg, parity_next;
  logic                   tx_reg, tx_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;
  logic                   tick, accept, last_data, frame_end;

  uart_transmitter_baud_tick_gen #(
    .FREQUENCY(FREQUENCY),
    .BAUDRATE (BAUDRATE)
  ) baud_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick)
  );

  assign last_data = (bit_cnt_reg == BIT_W'(WORD_LENGHT - 1));
  assign frame_end = (state_reg == TX_STOP) && tick && (bit_cnt_reg == BIT_W'(STOP_BITS - 1));
  // A request landing on the last stop-bit edge is taken so held-send frames abut exactly.
  assign accept    = bus.send && ((state_reg == TX_IDLE) || frame_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= TX_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    parity_next  = parity_reg;
    case (state_reg)
      TX_IDLE: ;
      TX_START: begin
        if (tick) state_next = TX_DATA;
      end
      TX_DATA: begin
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (last_data) begin
            bit_cnt_next = '0;
            state_next   = PARITY_EN ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tick) state_next = TX_STOP;
      end
      TX_STOP: begin
        if (frame_end) begin
          bit_cnt_next = '0;
          state_next   = TX_IDLE;
        end else if (tick) begin
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
        end
      end
      default: state_next = TX_IDLE;
    endcase
    if (accept) begin
      state_next   = TX_START;
      shift_next   = bus.TX_in;
      parity_next  = (^bus.TX_in) ^ PARITY_ODD;
      bit_cnt_next = '0;
    end
  end

  // Outputs are decoded from next-cycle values so the registered line tracks the state exactly.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != TX_IDLE);
    done_next = frame_end;
    case (state_next)
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = shift_next[0];
      TX_PARITY: tx_next = parity_next;
      default:   tx_next = 1'b1;
    endcase
  end

  assign bus.TX_out = tx_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule
